// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encoding and helpers for the universal shift register
//
// Contents:
//   USR_MODE_W  width of the mode select
//   usr_mode_e  operation codes sampled on each enabled edge
//   usr_is_step true for the modes that advance the shift counter

package usr_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD = 3'b000,
    USR_LOAD = 3'b001,
    USR_SHL  = 3'b010,
    USR_SHR  = 3'b011,
    USR_ROL  = 3'b100,
    USR_ROR  = 3'b101,
    USR_ASR  = 3'b110,
    USR_CLR  = 3'b111
  } usr_mode_e;

  // Shift, rotate and arithmetic-shift modes all count as one step of a pass.
  function automatic logic usr_is_step(input usr_mode_e m);
    return (m == USR_SHL) || (m == USR_SHR) || (m == USR_ROL) ||
           (m == USR_ROR) || (m == USR_ASR);
  endfunction

endpackage

// File: rtl/usr_next.sv
// rtl/usr_next.sv - combinational next-state datapath of the universal shift register
//
// Ports:
//   q          current register contents
//   d          parallel load data
//   mode       operation select
//   sin_l      serial bit entering at the LSB on SHL
//   sin_r      serial bit entering at the MSB on SHR
//   next_q     register value after the edge
//   next_sout  bit shifted or rotated out; 0 for LOAD/CLR, don't-care for HOLD

module usr_next
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  usr_mode_e        mode,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] next_q,
  output logic             next_sout
);

  always_comb begin
    next_q    = q;
    next_sout = 1'b0;
    case (mode)
      USR_HOLD: begin
        next_q    = q;
        next_sout = 1'b0;
      end
      USR_LOAD: begin
        next_q    = d;
        next_sout = 1'b0;
      end
      USR_SHL: begin
        next_q    = {q[WIDTH-2:0], sin_l};
        next_sout = q[WIDTH-1];
      end
      USR_SHR: begin
        next_q    = {sin_r, q[WIDTH-1:1]};
        next_sout = q[0];
      end
      USR_ROL: begin
        next_q    = {q[WIDTH-2:0], q[WIDTH-1]};
        next_sout = q[WIDTH-1];
      end
      USR_ROR: begin
        next_q    = {q[0], q[WIDTH-1:1]};
        next_sout = q[0];
      end
      USR_ASR: begin
        // Sign bit is replicated so signed values divide by two.
        next_q    = {q[WIDTH-1], q[WIDTH-1:1]};
        next_sout = q[0];
      end
      USR_CLR: begin
        next_q    = '0;
        next_sout = 1'b0;
      end
      default: begin
        next_q    = q;
        next_sout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/usr_reg.sv
// rtl/usr_reg.sv - WIDTH-bit universal shift register with serial out, zero flag and pass counter
//
// Ports:
//   clk        rising-edge clock
//   rest       asynchronous active-high reset
//   en         clock enable; 0 freezes all state including wrap
//   mode       operation select (usr_mode_e encoding)
//   d          parallel load data
//   sin_l      serial input at LSB for SHL
//   sin_r      serial input at MSB for SHR
//   q          register contents
//   sout       last bit shifted or rotated out
//   zero       registered q == 0 flag
//   shift_cnt  shift/rotate steps since LOAD/CLR/reset, modulo WIDTH
//   wrap       one-cycle pulse when shift_cnt wraps WIDTH-1 -> 0

module usr_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic                  en,
  input  logic [USR_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]      d,
  input  logic                  sin_l,
  input  logic                  sin_r,
  output logic [WIDTH-1:0]      q,
  output logic                  sout,
  output logic                  zero,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  wrap
);

  // Terminal count is explicit so non-power-of-two widths wrap at WIDTH-1.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  usr_mode_e        mode_e;
  logic [WIDTH-1:0] next_q;
  logic             next_sout;
  logic             step;
  logic             cnt_at_max;

  assign mode_e     = usr_mode_e'(mode);
  assign step       = usr_is_step(mode_e);
  assign cnt_at_max = (shift_cnt == CNT_MAX);

  usr_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q        (q),
    .d        (d),
    .mode     (mode_e),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .next_q   (next_q),
    .next_sout(next_sout)
  );

  // Data path: q, sout and zero move together so zero always matches q.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      q    <= RESET_VAL;
      sout <= 1'b0;
      zero <= (RESET_VAL == '0);
    end else if (en) begin
      q    <= next_q;
      zero <= (next_q == '0);
      if (mode_e != USR_HOLD) begin
        sout <= next_sout;
      end
    end
  end

  // Pass counter and wrap pulse. With en=0 wrap is held, stretching a pulse.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      shift_cnt <= '0;
      wrap      <= 1'b0;
    end else if (en) begin
      wrap <= 1'b0;
      if (mode_e == USR_LOAD || mode_e == USR_CLR) begin
        shift_cnt <= '0;
      end else if (step) begin
        if (cnt_at_max) begin
          shift_cnt <= '0;
          wrap      <= 1'b1;
        end else begin
          shift_cnt <= shift_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usr_reg.sv
// tb/tb_usr_reg.sv - scoreboard bench for usr_reg with directed vectors

module tb_usr_reg;
  import usr_pkg::*;

  logic       clk;
  logic       rest;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout;
  logic       zero;
  logic [2:0] shift_cnt;
  logic       wrap;

  usr_reg #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rest     (rest),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_l    (sin_l),
    .sin_r    (sin_r),
    .q        (q),
    .sout     (sout),
    .zero     (zero),
    .shift_cnt(shift_cnt),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       sout;
    logic       zero;
    logic [2:0] cnt;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compares DUT outputs against each queued expectation, either
  // at the falling edge after the issuing clock or on an explicit sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (q !== e.q || sout !== e.sout || zero !== e.zero ||
            shift_cnt !== e.cnt || wrap !== e.wrap) begin
          n_fail++;
          $display("FAIL %s: got q=%h sout=%b zero=%b cnt=%0d wrap=%b, want q=%h sout=%b zero=%b cnt=%0d wrap=%b",
                   e.name, q, sout, zero, shift_cnt, wrap,
                   e.q, e.sout, e.zero, e.cnt, e.wrap);
        end
      end
    end
  end

  function automatic void expect_state(input logic [7:0] eq, input logic es,
                                       input logic [2:0] ec, input logic ew,
                                       input string nm);
    exp_t e;
    e.q    = eq;
    e.sout = es;
    e.zero = (eq == 8'h00);
    e.cnt  = ec;
    e.wrap = ew;
    e.name = nm;
    sb.push_back(e);
  endfunction

  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv,
                      input logic sl, input logic sr,
                      input logic [7:0] eq, input logic es, input logic [2:0] ec,
                      input logic ew, input string nm);
    @(negedge clk);
    en    = e;
    mode  = m;
    d     = dv;
    sin_l = sl;
    sin_r = sr;
    @(posedge clk);
    expect_state(eq, es, ec, ew, nm);
  endtask

  // Reset checked between edges, with no clock edge in between.
  task automatic reset_check(input string nm);
    @(negedge clk);
    #2;
    rest = 1'b1;
    #1;
    expect_state(8'h00, 1'b0, 3'd0, 1'b0, nm);
    ->sample_ev;
    #1;
  endtask

  logic [7:0] rol_q[8];
  logic       rol_s[8];

  initial begin
    rest  = 1'b1;
    en    = 1'b0;
    mode  = USR_HOLD;
    d     = 8'h00;
    sin_l = 1'b0;
    sin_r = 1'b0;

    #2;
    expect_state(8'h00, 1'b0, 3'd0, 1'b0, "reset_initial");
    ->sample_ev;
    #1;

    @(negedge clk);
    rest = 1'b0;

    step(1, USR_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 3'd0, 0, "load_a5");
    step(1, USR_SHL,  8'h00, 1, 0, 8'h4B, 1, 3'd1, 0, "shl_sin1");
    step(1, USR_LOAD, 8'h80, 0, 0, 8'h80, 0, 3'd0, 0, "load_80a");
    step(1, USR_ASR,  8'h00, 1, 1, 8'hC0, 0, 3'd1, 0, "asr_80");
    step(1, USR_LOAD, 8'h80, 0, 0, 8'h80, 0, 3'd0, 0, "load_80b");
    step(1, USR_SHR,  8'h00, 1, 0, 8'h40, 0, 3'd1, 0, "shr_sin0");
    step(1, USR_LOAD, 8'h01, 0, 0, 8'h01, 0, 3'd0, 0, "load_01");
    step(1, USR_ROR,  8'h00, 0, 0, 8'h80, 1, 3'd1, 0, "ror_01");
    step(1, USR_SHR,  8'h00, 0, 1, 8'hC0, 0, 3'd2, 0, "shr_sin1");
    step(1, USR_HOLD, 8'hFF, 1, 1, 8'hC0, 0, 3'd2, 0, "hold");

    // Full pass: 0xA5 rotated left eight times returns to itself.
    rol_q = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
    rol_s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    step(1, USR_LOAD, 8'hA5, 0, 0, 8'hA5, 0, 3'd0, 0, "pass_load");
    for (int i = 0; i < 8; i++) begin
      step(1, USR_ROL, 8'h00, 0, 0, rol_q[i], rol_s[i], 3'((i + 1) % 8),
           (i == 7), $sformatf("pass_rol%0d", i + 1));
    end

    // Enable gating: LOAD with en=0 changes nothing and stretches wrap.
    for (int i = 0; i < 3; i++) begin
      step(0, USR_LOAD, 8'hFF, 1, 1, 8'hA5, 1, 3'd0, 1,
           $sformatf("en0_load%0d", i));
    end
    step(1, USR_CLR,  8'hFF, 0, 0, 8'h00, 0, 3'd0, 0, "clr");
    step(1, USR_LOAD, 8'h80, 0, 0, 8'h80, 0, 3'd0, 0, "load_80c");
    step(1, USR_SHL,  8'h00, 0, 0, 8'h00, 1, 3'd1, 0, "shl_to_zero");

    // Mid-pass reset after five rotate steps.
    step(1, USR_LOAD, 8'h0F, 0, 0, 8'h0F, 0, 3'd0, 0, "mid_load");
    rol_q = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F};
    rol_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      step(1, USR_ROL, 8'h00, 0, 0, rol_q[i], rol_s[i], 3'(i + 1), 0,
           $sformatf("mid_rol%0d", i + 1));
    end
    reset_check("reset_midpass");
    @(negedge clk);
    @(negedge clk);
    rest = 1'b0;

    step(1, USR_LOAD, 8'h0F, 0, 0, 8'h0F, 0, 3'd0, 0, "post_load");
    for (int i = 0; i < 8; i++) begin
      step(1, USR_ROL, 8'h00, 0, 0, rol_q[i], rol_s[i], 3'((i + 1) % 8),
           (i == 7), $sformatf("post_rol%0d", i + 1));
    end
    step(1, USR_HOLD, 8'h00, 0, 0, 8'h0F, 1, 3'd0, 0, "wrap_clears");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
